// File: rtl/fb_ddr_scheduler.sv
// Triple-buffered frame-buffer scheduler: arbitrates DDR3 burst commands
// between the capture write FIFO and the display read FIFO. It also rotates
// three frame buffers on the capture and display vsync edges.
module fb_ddr_scheduler #(
    parameter int unsigned ADDR_WIDTH  = 28,
    parameter int unsigned BURST_LEN   = 64,
    parameter int unsigned FRAME_WORDS = 76800,
    parameter int unsigned BUF_SHIFT   = 20,
    parameter int unsigned LVL_W       = 10,
    parameter int unsigned RD_LOW      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_calib_complete,
    input  logic                  wr_vsync,
    input  logic                  rd_vsync,
    input  logic [LVL_W-1:0]      wr_level,
    input  logic [LVL_W-1:0]      rd_level,
    input  logic                  cmd_ready,
    input  logic                  burst_done,
    output logic [2:0]            cmd,
    output logic                  cmd_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wr_grant,
    output logic                  rd_grant,
    output logic [1:0]            wr_buf_idx,
    output logic [1:0]            rd_buf_idx
);

    localparam int unsigned OFF_W = $clog2(FRAME_WORDS + 1);

    localparam logic [OFF_W-1:0] FRAME_OFF = OFF_W'(FRAME_WORDS);
    localparam logic [OFF_W-1:0] BURST_OFF = OFF_W'(BURST_LEN);
    localparam logic [LVL_W-1:0] BURST_LVL = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0] RD_LVL    = LVL_W'(RD_LOW);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } state_t;

    state_t                  state_q;
    logic                    cmd_en_q;
    logic [2:0]              cmd_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wr_grant_q;
    logic                    rd_grant_q;
    logic [1:0]              wr_idx_q;
    logic [1:0]              rd_idx_q;
    logic [1:0]              last_q;
    logic [OFF_W-1:0]        wr_off_q;
    logic [OFF_W-1:0]        rd_off_q;
    logic                    pri_q;
    logic                    rd_sel_q;
    logic                    wr_vs_q;
    logic                    rd_vs_q;
    logic                    wr_pend_q;
    logic                    rd_pend_q;

    // IDLE view: pending vsync updates applied first, then arbitration
    logic                    wr_rise;
    logic                    rd_rise;
    logic [1:0]              wr_idx_d;
    logic [1:0]              rd_idx_d;
    logic [1:0]              last_d;
    logic [OFF_W-1:0]        wr_off_d;
    logic [OFF_W-1:0]        rd_off_d;
    logic                    wr_req;
    logic                    rd_req;
    logic                    pick_rd;
    logic [1:0]              pick_idx;
    logic [OFF_W-1:0]        pick_off;
    logic [ADDR_WIDTH-1:0]   pick_addr;

    // Vsync edge detection, pending-update application and arbitration
    always_comb begin
        wr_rise  = wr_vsync & ~wr_vs_q;
        rd_rise  = rd_vsync & ~rd_vs_q;

        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        last_d   = last_q;
        wr_off_d = wr_off_q;
        rd_off_d = rd_off_q;

        // Write swap runs before the read swap so a simultaneous read
        // vsync picks up the frame that has just been completed.
        if (wr_pend_q) begin
            if (wr_off_q == FRAME_OFF) begin
                last_d   = wr_idx_q;
                // wr and rd indices are always distinct, so this is the third buffer
                wr_idx_d = 2'd3 - wr_idx_q - rd_idx_q;
            end
            wr_off_d = '0;
        end
        if (rd_pend_q) begin
            rd_idx_d = last_d;
            rd_off_d = '0;
        end

        wr_req  = init_calib_complete && (wr_level >= BURST_LVL) && (wr_off_d < FRAME_OFF);
        rd_req  = init_calib_complete && (rd_level <= RD_LVL) && (rd_off_d < FRAME_OFF);
        pick_rd = rd_req && (!wr_req || pri_q);

        pick_idx  = pick_rd ? rd_idx_d : wr_idx_d;
        pick_off  = pick_rd ? rd_off_d : wr_off_d;
        pick_addr = (ADDR_WIDTH'(pick_idx) << BUF_SHIFT) + ADDR_WIDTH'(pick_off);
    end

    // Scheduler state machine with registered command/grant/buffer outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_en_q   <= 1'b0;
            cmd_q      <= '0;
            addr_q     <= '0;
            wr_grant_q <= 1'b0;
            rd_grant_q <= 1'b0;
            wr_idx_q   <= 2'd0;
            rd_idx_q   <= 2'd1;
            last_q     <= 2'd1;
            wr_off_q   <= '0;
            rd_off_q   <= '0;
            pri_q      <= 1'b0;
            rd_sel_q   <= 1'b0;
            wr_vs_q    <= 1'b0;
            rd_vs_q    <= 1'b0;
            wr_pend_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
        end else begin
            wr_vs_q   <= wr_vsync;
            rd_vs_q   <= rd_vsync;
            // Pending flags clear when consumed in IDLE; a fresh edge on the
            // same cycle is kept, repeated edges before use merge into one.
            wr_pend_q <= (wr_pend_q && (state_q != ST_IDLE)) || wr_rise;
            rd_pend_q <= (rd_pend_q && (state_q != ST_IDLE)) || rd_rise;

            case (state_q)
                ST_IDLE: begin
                    wr_idx_q <= wr_idx_d;
                    rd_idx_q <= rd_idx_d;
                    last_q   <= last_d;
                    wr_off_q <= wr_off_d;
                    rd_off_q <= rd_off_d;
                    if (wr_req || rd_req) begin
                        state_q  <= ST_CMD;
                        cmd_en_q <= 1'b1;
                        cmd_q    <= {2'b00, pick_rd};
                        addr_q   <= pick_addr;
                        rd_sel_q <= pick_rd;
                        pri_q    <= ~pick_rd;
                    end
                end
                ST_CMD: begin
                    if (cmd_ready) begin
                        state_q    <= ST_DATA;
                        cmd_en_q   <= 1'b0;
                        wr_grant_q <= ~rd_sel_q;
                        rd_grant_q <= rd_sel_q;
                    end
                end
                ST_DATA: begin
                    if (burst_done) begin
                        state_q    <= ST_IDLE;
                        wr_grant_q <= 1'b0;
                        rd_grant_q <= 1'b0;
                        if (rd_sel_q) begin
                            rd_off_q <= rd_off_q + BURST_OFF;
                        end else begin
                            wr_off_q <= wr_off_q + BURST_OFF;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_en     = cmd_en_q;
    assign cmd        = cmd_q;
    assign addr       = addr_q;
    assign wr_grant   = wr_grant_q;
    assign rd_grant   = rd_grant_q;
    assign wr_buf_idx = wr_idx_q;
    assign rd_buf_idx = rd_idx_q;

endmodule
